pixel_stream_source: RTL and testbench
======================================

PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 SHALL have parameter IMG_W, default 800, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 600, rows per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 2, memory word address of the first pixel (header words skipped).
REQ-004 SHALL have parameter ADDR_W, default 19, memory address width.
REQ-005 SHALL have ports in this order:
clk  in  1  single clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle request to stream one frame.
mem_en  out  1  memory read strobe.
mem_addr  out  ADDR_W  memory read address.
mem_dout  in  8  read data, valid exactly 1 cycle after mem_en.
rd_en  in  1  consumer read enable (driven by the Gaussian wrapper rd_en_down).
dout  out  8  current pixel, first-word-fall-through.
valid  out  1  dout holds a pixel.
empty  out  1  always ~valid.
sof  out  1  dout is pixel (0,0).
eol  out  1  dout is last pixel of a row.
eof  out  1  dout is last pixel of the frame.
busy  out  1  frame in progress.
done  out  1  one-cycle pulse after the last pixel is consumed.

Function
REQ-006 SHALL transfer one pixel per cycle in which valid and rd_en are both high; rd_en while empty SHALL be ignored with no state change.
REQ-007 SHALL hold dout, sof, eol and eof stable while valid is high and rd_en is low.
REQ-008 SHALL implement FSM IDLE -> FETCH on start; FETCH -> DRAIN after issuing read IMG_W*IMG_H-1; DRAIN -> DONE when the last pixel is consumed; DONE -> IDLE after one cycle.
REQ-009 start outside IDLE SHALL be ignored.
REQ-010 SHALL issue reads in raster order from BASE_ADDR to BASE_ADDR+IMG_W*IMG_H-1, one address per mem_en cycle, with no skipped or repeated addresses.
REQ-011 SHALL assert mem_en only when buffer occupancy plus reads in flight is less than 3.
REQ-012 For start sampled at edge k, mem_en SHALL be high in cycle k+1 and valid SHALL rise after edge k+2.
REQ-013 With rd_en held high, SHALL sustain one pixel per cycle with no bubbles after the first pixel.
REQ-014 SHALL compute sof, eol and eof from column and row counters that advance on consumption only; the column SHALL wrap at IMG_W-1 and the row SHALL increment on wrap.
REQ-015 busy SHALL be high in FETCH, DRAIN and DONE; done SHALL be high only in DONE.
REQ-016 Counter arithmetic SHALL be at least ADDR_W bits wide so that IMG_W*IMG_H+BASE_ADDR does not overflow.

Reset
REQ-017 On rst low, SHALL immediately enter IDLE, empty the buffer, discard in-flight reads and zero the counters.
REQ-018 During reset, outputs SHALL be: mem_en=0, mem_addr=0, dout=0, valid=0, empty=1, sof=eol=eof=0, busy=0, done=0.
REQ-019 Reset asserted mid-frame SHALL abort the frame with no done pulse.

Configuration
REQ-020 With macro PIXSRC_LOOP_EN defined, DONE SHALL return to FETCH with addresses restarting at BASE_ADDR, giving continuous frames.
REQ-021 With PIXSRC_LOOP_EN defined, done SHALL still pulse once per frame and busy SHALL stay high.
REQ-022 Without PIXSRC_LOOP_EN, SHALL behave as REQ-008.

Structure
REQ-023 Package pixsrc_pkg SHALL hold the FSM state typedef (IDLE, FETCH, DRAIN, DONE), the default IMG_W, IMG_H and BASE_ADDR constants, and the buffer depth constant of 3.
REQ-024 SHALL instantiate one sub-module, pixsrc_skid_fifo: a 3-entry FWFT buffer carrying pixel data plus the sof/eol/eof tags.

Verification
REQ-025 IMG_W=4, IMG_H=2, memory holding its address, rd_en=1, start at edge 5 -> mem_en in cycle 6, valid after edge 7, dout sequence 2..9, eol on 5 and 9, eof on 9, done one cycle after 9 is consumed.
REQ-026 Same setup, rd_en toggled 1,0,1,0 -> each pixel delivered exactly once, dout stable during rd_en=0, mem_en never issued with occupancy plus in-flight at 3.
REQ-027 rd_en held low after start -> exactly 3 reads issued, valid=1, dout=2 held.
REQ-028 start pulsed again mid-frame -> ignored; address sequence unchanged.
REQ-029 rst low after pixel 4 -> all outputs at REQ-018 values immediately; the next start restarts at address 2 with sof set.
REQ-030 PIXSRC_LOOP_EN defined, 2 frames -> second sof follows eof with no bubble, two done pulses, busy stays high.

Source files
------------

// File: rtl/pixsrc_pkg.sv
// ============================================================================
// Module   : pixsrc_pkg
// Purpose  : Shared types and constants for the pixel stream source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixsrc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pixsrc_state_t;

    localparam int c_IMG_W_DEF     = 800;
    localparam int c_IMG_H_DEF     = 600;
    localparam int c_BASE_ADDR_DEF = 2;
    localparam int c_BUF_DEPTH     = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } pixsrc_pix_t;

    // Modulo-3 pointer advance for the buffer.
    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(c_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixsrc_if.sv
// ============================================================================
// Module   : pixsrc_if
// Purpose  : FWFT pixel stream bundle (data, tags, valid, consumer read enable).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixsrc_if;
    logic [7:0] data;
    logic       valid;
    logic       sof;
    logic       eol;
    logic       eof;
    logic       rd_en;

    modport master (output data, valid, sof, eol, eof, input rd_en);
    modport slave  (input data, valid, sof, eol, eof, output rd_en);
endinterface

`default_nettype wire

// File: rtl/pixsrc_skid_fifo.sv
// ============================================================================
// Module   : pixsrc_skid_fifo
// Purpose  : 3-entry first-word-fall-through buffer for pixel data plus tags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixsrc_skid_fifo
    import pixsrc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  pixsrc_pix_t     push_pix_i,
    output logic [1:0]      count_o,
    pixsrc_if.master        pop_if
);

    pixsrc_pix_t ent_q [c_BUF_DEPTH];
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [1:0]  count_q;
    logic        nonempty;
    logic        pop;
    pixsrc_pix_t head;

    assign nonempty = (count_q != 2'd0);
    // A read enable against an empty buffer is simply dropped.
    assign pop      = pop_if.rd_en && nonempty;
    assign head     = ent_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                ent_q[wr_ptr_q] <= push_pix_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push_i, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Outputs are forced to zero when empty so stale entries never leak out.
    assign pop_if.valid = nonempty;
    assign pop_if.data  = nonempty ? head.data : 8'h00;
    assign pop_if.sof   = nonempty && head.sof;
    assign pop_if.eol   = nonempty && head.eol;
    assign pop_if.eof   = nonempty && head.eof;
    assign count_o      = count_q;

endmodule

`default_nettype wire

// File: rtl/pixel_stream_source.sv
// ============================================================================
// Module   : pixel_stream_source
// Purpose  : Streams one frame from memory in raster order as an FWFT source.
//            Define PIXSRC_LOOP_EN for continuous back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_stream_source
    import pixsrc_pkg::*;
#(
    parameter int IMG_W     = c_IMG_W_DEF,
    parameter int IMG_H     = c_IMG_H_DEF,
    parameter int BASE_ADDR = c_BASE_ADDR_DEF,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    input  logic              rd_en,
    output logic [7:0]        dout,
    output logic              valid,
    output logic              empty,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] c_LAST_COL = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ROW = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

    pixsrc_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic [ADDR_W-1:0] fcol_q;
    logic [ADDR_W-1:0] frow_q;
    logic [ADDR_W-1:0] ccol_q;
    logic [ADDR_W-1:0] crow_q;
    logic              inflight_q;

    logic [1:0]        fifo_count;
    logic              issue_ok;
    logic              last_read;
    logic              pop;
    logic              fill_eol;
    logic              fill_eof;
    logic              cons_eol;
    logic              cons_eof;
    pixsrc_pix_t       push_pix;

    pixsrc_if u_pop_if ();

`ifdef PIXSRC_LOOP_EN
    // Next frame is prefetched while the current one drains, so no bubble.
    assign issue_ok = (state_q != IDLE);
`else
    assign issue_ok = (state_q == FETCH);
`endif

    assign mem_en    = issue_ok &&
                       (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'(c_BUF_DEPTH));
    assign last_read = mem_en && (rd_idx_q == c_LAST_IDX);

    // Tags ride with the data; fill position tracks returning reads.
    assign fill_eol      = (fcol_q == c_LAST_COL);
    assign fill_eof      = fill_eol && (frow_q == c_LAST_ROW);
    assign push_pix.data = mem_dout;
    assign push_pix.sof  = (fcol_q == '0) && (frow_q == '0);
    assign push_pix.eol  = fill_eol;
    assign push_pix.eof  = fill_eof;

    assign u_pop_if.rd_en = rd_en;
    assign pop            = u_pop_if.valid && rd_en;
    assign cons_eol       = (ccol_q == c_LAST_COL);
    assign cons_eof       = cons_eol && (crow_q == c_LAST_ROW);

    pixsrc_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_pix_i (push_pix),
        .count_o    (fifo_count),
        .pop_if     (u_pop_if)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_idx_q   <= '0;
            fcol_q     <= '0;
            frow_q     <= '0;
            ccol_q     <= '0;
            crow_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= mem_en;

            if (mem_en) begin
                if (last_read) begin
                    rd_idx_q <= '0;
                    addr_q   <= c_BASE;
                end else begin
                    rd_idx_q <= rd_idx_q + c_ONE;
                    addr_q   <= addr_q + c_ONE;
                end
            end

            if (inflight_q) begin
                if (fill_eol) begin
                    fcol_q <= '0;
                    frow_q <= fill_eof ? '0 : frow_q + c_ONE;
                end else begin
                    fcol_q <= fcol_q + c_ONE;
                end
            end

            // Consumption position advances only on an accepted pixel.
            if (pop) begin
                if (cons_eol) begin
                    ccol_q <= '0;
                    crow_q <= cons_eof ? '0 : crow_q + c_ONE;
                end else begin
                    ccol_q <= ccol_q + c_ONE;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= FETCH;
                        addr_q   <= c_BASE;
                        rd_idx_q <= '0;
                        fcol_q   <= '0;
                        frow_q   <= '0;
                        ccol_q   <= '0;
                        crow_q   <= '0;
                    end
                end
                FETCH: begin
                    if (last_read) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && cons_eof) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
`ifdef PIXSRC_LOOP_EN
                    state_q <= FETCH;
`else
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr = addr_q;
    assign dout     = u_pop_if.data;
    assign valid    = u_pop_if.valid;
    assign empty    = ~u_pop_if.valid;
    assign sof      = u_pop_if.sof;
    assign eol      = u_pop_if.eol;
    assign eof      = u_pop_if.eof;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_source.sv
// ============================================================================
// Module   : tb_pixel_stream_source
// Purpose  : Scoreboard bench for pixel_stream_source on a 4x2 image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_stream_source;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int BASE = 2;
    localparam int AW   = 19;
    localparam int NPIX = W * H;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dout = 8'h00;
    logic          empty;
    logic          busy;
    logic          done;

    pixsrc_if bus ();

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory whose word holds its own address, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= mem_addr[7:0];
    end

    pixel_stream_source #(
        .IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE), .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .rd_en    (bus.rd_en),
        .dout     (bus.data),
        .valid    (bus.valid),
        .empty    (empty),
        .sof      (bus.sof),
        .eol      (bus.eol),
        .eof      (bus.eof),
        .busy     (busy),
        .done     (done)
    );

    // Observation log, sampled on the falling edge.
    int            cyc_n    = 0;
    int            n_got    = 0;
    int            n_addr   = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            issued   = 0;
    int            popped   = 0;
    int            viol     = 0;
    bit            log_clr  = 1'b0;
    logic [10:0]   got_pix  [64];
    int            got_cyc  [64];
    logic [AW-1:0] got_addr [64];
    logic [10:0]   exp_q [$];

    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (!rst) begin
            issued <= 0;
            popped <= 0;
        end else begin
            issued <= issued + (mem_en ? 1 : 0);
            popped <= popped + ((bus.valid && bus.rd_en) ? 1 : 0);
        end
        if (log_clr) begin
            n_got    <= 0;
            n_addr   <= 0;
            done_cnt <= 0;
            viol     <= 0;
        end else begin
            if (rst && mem_en && (issued - popped) >= 3) viol <= viol + 1;
            if (bus.valid && bus.rd_en && n_got < 64) begin
                got_pix[n_got] <= {bus.data, bus.sof, bus.eol, bus.eof};
                got_cyc[n_got] <= cyc_n;
                n_got          <= n_got + 1;
            end
            if (mem_en && n_addr < 64) begin
                got_addr[n_addr] <= mem_addr;
                n_addr           <= n_addr + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc_n;
            end
        end
    end

    function automatic logic [10:0] exp_pix(input int i);
        int col;
        int row;
        col = i % W;
        row = i / W;
        return {8'(BASE + i), (col == 0 && row == 0), (col == W - 1),
                (col == W - 1 && row == H - 1)};
    endfunction

    task automatic push_frame_exp();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(exp_pix(i));
    endtask

    task automatic clear_log();
        exp_q.delete();
        @(posedge clk);
        #1 log_clr = 1'b1;
        @(posedge clk);
        #1 log_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [AW+15:0] obs;
        logic [AW+15:0] expv;
        #1 rst = 1'b0;
        #2;
        expv = {1'b0, {AW{1'b0}}, 8'h00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
        obs  = {mem_en, mem_addr, bus.data, bus.valid, empty, bus.sof, bus.eol, bus.eof, busy, done};
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", obs, expv);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, mem_en} !== 2'b00) begin
            failures++;
            $display("FAIL start_in_reset: busy/mem_en got %b expected 00", {busy, mem_en});
        end
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_frame_basic();
        bit ok;
        logic [10:0] e;
        clear_log();
        push_frame_exp();
        bus.rd_en = 1'b1;
        pulse_start();
        @(negedge clk);
        checks++;
        if ({mem_en, mem_addr, bus.valid} !== {1'b1, AW'(BASE), 1'b0}) begin
            failures++;
            $display("FAIL first_read: en/addr/valid got %b/%0d/%b expected 1/%0d/0", mem_en, mem_addr, bus.valid, BASE);
        end
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_early: got %b expected 0", bus.valid);
        end
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.data, bus.sof} !== {1'b1, 8'(BASE), 1'b1}) begin
            failures++;
            $display("FAIL first_pixel: valid/dout/sof got %b/%0d/%b expected 1/%0d/1", bus.valid, bus.data, bus.sof, BASE);
        end
        wait_done(1, 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout: done got 0 expected 1");
        end
        checks++;
        if (n_got != NPIX || n_addr != NPIX) begin
            failures++;
            $display("FAIL basic_counts: pixels/reads got %0d/%0d expected %0d", n_got, n_addr, NPIX);
        end
        for (int i = 0; i < n_got && i < NPIX; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_pix[i] !== e) begin
                failures++;
                $display("FAIL basic_pix%0d: got %h expected %h", i, got_pix[i], e);
            end
            checks++;
            if (got_addr[i] !== AW'(BASE + i)) begin
                failures++;
                $display("FAIL basic_addr%0d: got %0d expected %0d", i, got_addr[i], BASE + i);
            end
        end
        checks++;
        if (got_cyc[NPIX-1] - got_cyc[0] != NPIX - 1) begin
            failures++;
            $display("FAIL basic_bubble: span got %0d expected %0d", got_cyc[NPIX-1] - got_cyc[0], NPIX - 1);
        end
        checks++;
        if (done_cyc != got_cyc[NPIX-1] + 1) begin
            failures++;
            $display("FAIL done_timing: cycle got %0d expected %0d", done_cyc, got_cyc[NPIX-1] + 1);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, bus.valid} !== 3'b000 || done_cnt != 1) begin
            failures++;
            $display("FAIL done_pulse: done/busy/valid %b%b%b cnt %0d expected 000 cnt 1", done, busy, bus.valid, done_cnt);
        end
    endtask

    task automatic test_rd_toggle();
        bit          ok;
        bit          hold_pend;
        logic [10:0] hold_val;
        logic [10:0] e;
        clear_log();
        push_frame_exp();
        bus.rd_en = 1'b0;
        hold_pend = 1'b0;
        hold_val  = '0;
        ok        = 1'b0;
        pulse_start();
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            if (done_cnt >= 1) begin
                ok = 1'b1;
                break;
            end
            #1 bus.rd_en = (i % 2 == 0);
            @(negedge clk);
            if (hold_pend) begin
                checks++;
                if ({bus.data, bus.sof, bus.eol, bus.eof} !== hold_val) begin
                    failures++;
                    $display("FAIL toggle_hold: got %h expected %h", {bus.data, bus.sof, bus.eol, bus.eof}, hold_val);
                end
            end
            hold_pend = bus.valid && !bus.rd_en;
            hold_val  = {bus.data, bus.sof, bus.eol, bus.eof};
        end
        bus.rd_en = 1'b1;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL toggle_timeout: done got 0 expected 1");
        end
        checks++;
        if (n_got != NPIX || n_addr != NPIX || viol != 0) begin
            failures++;
            $display("FAIL toggle_counts: pixels/reads/overissue got %0d/%0d/%0d expected %0d/%0d/0", n_got, n_addr, viol, NPIX, NPIX);
        end
        for (int i = 0; i < n_got && i < NPIX; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_pix[i] !== e) begin
                failures++;
                $display("FAIL toggle_pix%0d: got %h expected %h", i, got_pix[i], e);
            end
        end
    endtask

    task automatic test_rd_low();
        bit          ok;
        logic [10:0] e;
        clear_log();
        push_frame_exp();
        bus.rd_en = 1'b0;
        pulse_start();
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (n_addr != 3 || {bus.valid, bus.data, bus.sof} !== {1'b1, 8'(BASE), 1'b1}) begin
            failures++;
            $display("FAIL rdlow_stall: reads %0d valid/dout/sof %b/%0d/%b expected 3 1/%0d/1", n_addr, bus.valid, bus.data, bus.sof, BASE);
        end
        @(posedge clk);
        #1 bus.rd_en = 1'b1;
        wait_done(1, 40, ok);
        checks++;
        if (!ok || n_got != NPIX || n_addr != NPIX) begin
            failures++;
            $display("FAIL rdlow_finish: done %b pixels/reads %0d/%0d expected 1 %0d/%0d", ok, n_got, n_addr, NPIX, NPIX);
        end
        for (int i = 0; i < n_got && i < NPIX; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_pix[i] !== e) begin
                failures++;
                $display("FAIL rdlow_pix%0d: got %h expected %h", i, got_pix[i], e);
            end
        end
    endtask

    task automatic test_restart_ignored();
        bit ok;
        clear_log();
        bus.rd_en = 1'b1;
        pulse_start();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1, 40, ok);
        checks++;
        if (!ok || n_addr != NPIX) begin
            failures++;
            $display("FAIL restart_reads: done %b reads got %0d expected %0d", ok, n_addr, NPIX);
        end
        for (int i = 0; i < n_addr && i < NPIX; i++) begin
            checks++;
            if (got_addr[i] !== AW'(BASE + i)) begin
                failures++;
                $display("FAIL restart_addr%0d: got %0d expected %0d", i, got_addr[i], BASE + i);
            end
        end
        repeat (5) @(posedge clk);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_extra: done pulses %0d busy %b expected 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_reset_abort();
        bit             ok;
        logic [10:0]    e;
        logic [AW+15:0] obs;
        logic [AW+15:0] expv;
        clear_log();
        bus.rd_en = 1'b1;
        ok        = 1'b0;
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (n_got >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        #2 rst = 1'b0;
        #1;
        expv = {1'b0, {AW{1'b0}}, 8'h00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
        obs  = {mem_en, mem_addr, bus.data, bus.valid, empty, bus.sof, bus.eol, bus.eof, busy, done};
        checks++;
        if (!ok || obs !== expv) begin
            failures++;
            $display("FAIL abort_outputs: reached %b got %h expected %h", ok, obs, expv);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_done: done pulses %0d busy %b expected 0 0", done_cnt, busy);
        end
        clear_log();
        push_frame_exp();
        pulse_start();
        wait_done(1, 40, ok);
        checks++;
        if (!ok || n_got != NPIX || got_addr[0] !== AW'(BASE)) begin
            failures++;
            $display("FAIL abort_restart: done %b pixels %0d first addr %0d expected 1 %0d %0d", ok, n_got, got_addr[0], NPIX, BASE);
        end
        for (int i = 0; i < n_got && i < NPIX; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_pix[i] !== e) begin
                failures++;
                $display("FAIL abort_pix%0d: got %h expected %h", i, got_pix[i], e);
            end
        end
    endtask

`ifdef PIXSRC_LOOP_EN
    task automatic test_loop();
        bit          ok;
        int          busy_low;
        logic [10:0] e;
        clear_log();
        push_frame_exp();
        push_frame_exp();
        bus.rd_en = 1'b1;
        busy_low  = 0;
        ok        = 1'b0;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            @(posedge clk);
            if (done_cnt >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || done_cnt != 2 || busy_low != 0 || n_got < 2 * NPIX) begin
            failures++;
            $display("FAIL loop_status: done %b pulses %0d busy_low %0d pixels %0d expected 1 2 0 >=%0d", ok, done_cnt, busy_low, n_got, 2 * NPIX);
        end
        for (int i = 0; i < n_got && i < 2 * NPIX; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_pix[i] !== e || got_addr[i] !== AW'(BASE + (i % NPIX))) begin
                failures++;
                $display("FAIL loop_pix%0d: got %h/%0d expected %h/%0d", i, got_pix[i], got_addr[i], e, BASE + (i % NPIX));
            end
        end
        checks++;
        if (got_cyc[2*NPIX-1] - got_cyc[0] != 2 * NPIX - 1) begin
            failures++;
            $display("FAIL loop_bubble: span got %0d expected %0d", got_cyc[2*NPIX-1] - got_cyc[0], 2 * NPIX - 1);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask
`endif

    initial begin
        bus.rd_en = 1'b0;
        test_reset();
`ifdef PIXSRC_LOOP_EN
        test_loop();
`else
        test_frame_basic();
        test_rd_toggle();
        test_rd_low();
        test_restart_ignored();
        test_reset_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
